// File: rtl/timer_apb_multi_if.sv
// APB bus bundle between the peripheral segment master and timer_apb_multi.
interface timer_apb_multi_if;
    logic        psel;
    logic [7:0]  paddr;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (output psel, paddr, penable, pwrite, pwdata,
                    input  prdata, pready, pslverr);
    modport slave  (input  psel, paddr, penable, pwrite, pwdata,
                    output prdata, pready, pslverr);
endinterface

// File: rtl/timer_apb_multi.sv
// Multi-channel APB timer: NUM_CH up-counters sharing one prescaler, each with
// compare/reload, periodic or one-shot mode and a maskable W1C interrupt.
module timer_apb_multi #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 32,
    parameter int PRESC_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    timer_apb_multi_if.slave  apb,
    output logic              irq_o,
    output logic [NUM_CH-1:0] irq_ch_o
);
    localparam logic [31:0] ID_VAL = {8'h54, 8'(NUM_CH), 8'(CNT_W), 8'(PRESC_W)};

    logic [NUM_CH-1:0]  en_q, en_d, os_q, os_d, ie_q, ie_d, pend_q, pend_d;
    logic [CNT_W-1:0]   load_q [NUM_CH];
    logic [CNT_W-1:0]   load_d [NUM_CH];
    logic [CNT_W-1:0]   cnt_q  [NUM_CH];
    logic [CNT_W-1:0]   cnt_d  [NUM_CH];
    logic [PRESC_W-1:0] presc_q, presc_d, pcnt_q, pcnt_d;

    logic              access, wr, tick;
    logic              is_presc, is_status, is_id;
    logic [2:0]        ch_idx;
    logic [1:0]        reg_off;
    logic [NUM_CH-1:0] ch_sel;
    logic              unused_bits;

    assign unused_bits = ^{apb.paddr[1:0], apb.pwdata};

    always_comb begin
        access    = apb.psel & apb.penable;
        wr        = access & apb.pwrite;
        ch_idx    = apb.paddr[6:4];
        reg_off   = apb.paddr[3:2];
        is_presc  = (apb.paddr[7:2] == 6'h20);
        is_status = (apb.paddr[7:2] == 6'h21);
        is_id     = (apb.paddr[7:2] == 6'h22);
        ch_sel    = '0;
        // Offset 0xC is a hole inside each channel window.
        for (int c = 0; c < NUM_CH; c++)
            ch_sel[c] = !apb.paddr[7] && (ch_idx == 3'(c)) && (reg_off != 2'd3);
    end

    assign tick = (pcnt_q == presc_q);

    always_comb begin
        apb.prdata  = '0;
        apb.pslverr = 1'b0;
        if (access) begin
            apb.pslverr = !(|ch_sel || is_presc || is_status || is_id);
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_sel[c]) begin
                    case (reg_off)
                        2'd0:    apb.prdata = {29'd0, ie_q[c], os_q[c], en_q[c]};
                        2'd1:    apb.prdata = 32'(load_q[c]);
                        default: apb.prdata = 32'(cnt_q[c]);
                    endcase
                end
            end
            if (is_presc)  apb.prdata = 32'(presc_q);
            if (is_status) apb.prdata = 32'(pend_q);
            if (is_id)     apb.prdata = ID_VAL;
        end
    end

    assign apb.pready = 1'b1;

    always_comb begin
        en_d    = en_q;
        os_d    = os_q;
        ie_d    = ie_q;
        load_d  = load_q;
        cnt_d   = cnt_q;
        presc_d = presc_q;
        pcnt_d  = tick ? '0 : pcnt_q + PRESC_W'(1);
        // Clear first so a same-edge expiry below re-sets the bit.
        pend_d  = (wr && is_status) ? (pend_q & ~apb.pwdata[NUM_CH-1:0]) : pend_q;
        for (int c = 0; c < NUM_CH; c++) begin
            // A COUNT write on a tick edge suppresses that edge's count/expiry.
            if (tick && en_q[c] && !(wr && ch_sel[c] && reg_off == 2'd2)) begin
                if (cnt_q[c] >= load_q[c]) begin
                    pend_d[c] = 1'b1;
                    if (os_q[c]) en_d[c]  = 1'b0;
                    else         cnt_d[c] = '0;
                end else begin
                    cnt_d[c] = cnt_q[c] + CNT_W'(1);
                end
            end
            if (wr && ch_sel[c]) begin
                case (reg_off)
                    2'd0:    {ie_d[c], os_d[c], en_d[c]} = apb.pwdata[2:0];
                    2'd1:    load_d[c] = apb.pwdata[CNT_W-1:0];
                    default: cnt_d[c]  = apb.pwdata[CNT_W-1:0];
                endcase
            end
        end
        if (wr && is_presc) begin
            presc_d = apb.pwdata[PRESC_W-1:0];
            pcnt_d  = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            en_q    <= '0;
            os_q    <= '0;
            ie_q    <= '0;
            pend_q  <= '0;
            presc_q <= '0;
            pcnt_q  <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                load_q[c] <= '0;
                cnt_q[c]  <= '0;
            end
        end else begin
            en_q    <= en_d;
            os_q    <= os_d;
            ie_q    <= ie_d;
            pend_q  <= pend_d;
            presc_q <= presc_d;
            pcnt_q  <= pcnt_d;
            load_q  <= load_d;
            cnt_q   <= cnt_d;
        end
    end

    assign irq_ch_o = pend_q & ie_q;
    assign irq_o    = |irq_ch_o;
endmodule
